display_scan_ctrl: RTL and testbench
====================================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter PRESCALE, default 50000, sets the number of CLK cycles between SEL toggles; legal range is 1 to 2^20-1.
REQ-002 CLK  input  1  single system clock; all state changes on its rising edge.
REQ-003 RST_N  input  1  reset, synchronous, active-low.
REQ-004 VALUE  input  7  unsigned binary value to display (ALU result), range 0..127.
REQ-005 LOAD  input  1  one-cycle start strobe; sampled only in IDLE.
REQ-006 J  output  4  BCD tens digit, feeds the downstream digit mux J input.
REQ-007 K  output  4  BCD units digit, feeds the downstream digit mux K input.
REQ-008 SEL  output  1  digit-select square wave, feeds the downstream mux select.
REQ-009 BUSY  output  1  high while a conversion is in progress.
REQ-010 OVF  output  1  high when the last converted VALUE exceeded 99.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-012 IDLE with LOAD=1 at edge 0 SHALL capture VALUE into a 7-bit shift register, clear the 8-bit BCD scratch register, clear the bit counter, and go to SHIFT.
REQ-013 SHIFT SHALL run 7 shift-add-3 iterations, one per edge 1..7, and go to DONE after the 7th.
  - Before each shift, each BCD nibble >= 5 gets +3.
  - Then {scratch, shift register} shifts left by 1.
REQ-014 DONE (edge 8) SHALL register J and K from the scratch nibbles, update OVF, and return to IDLE.
REQ-015 Total latency SHALL be 8 cycles: J, K and OVF change only at edge 8.
REQ-016 BUSY SHALL be 1 from after edge 0 until edge 8; BUSY SHALL be 0 after edge 8.
REQ-017 LOAD SHALL be ignored in SHIFT and DONE.
REQ-018 A new LOAD is accepted in IDLE on the cycle immediately after DONE (back-to-back throughput of 9 cycles).
REQ-019 J, K and OVF SHALL hold their values between conversions.
REQ-020 Scratch arithmetic is 4 bits per nibble; a hundreds carry out of the tens nibble SHALL be discarded.
REQ-021 The refresh counter SHALL count 0..PRESCALE-1 and wrap to 0.
  - SEL toggles on the edge where the counter wraps.
  - SEL period is 2*PRESCALE cycles.
  - With PRESCALE=1, SEL toggles every cycle.
REQ-022 The refresh counter and SEL SHALL run independently of the FSM and SHALL NOT pause during a conversion.

Reset
REQ-023 With RST_N=0 at an edge, the following SHALL be reset at that edge, including mid-conversion:
  - FSM to IDLE.
  - J=0, K=0, OVF=0, BUSY=0, SEL=0.
  - Refresh counter, shift register, scratch register and bit counter all to 0.
REQ-024 A LOAD coincident with RST_N=0 SHALL be discarded.
REQ-025 The first LOAD is accepted on the first edge with RST_N=1.

Configuration
REQ-026 Macro DISPLAY_SATURATE_EN: when defined and VALUE > 99, DONE SHALL output J=9, K=9 and OVF=1.
REQ-027 When DISPLAY_SATURATE_EN is not defined and VALUE > 99, DONE SHALL output the tens and units of VALUE-100 with OVF=1 (e.g. 127 gives J=2, K=7).
REQ-028 For VALUE <= 99, behaviour SHALL be identical with or without the macro, with OVF=0.

Verification
REQ-029 Reset, then LOAD with VALUE=47 -> BUSY high for edges 1..8; J=4, K=7, OVF=0 after edge 8; BUSY=0 after edge 8.
REQ-030 Sweep VALUE 0..99, one LOAD every 9 cycles -> {J,K} equals the decimal digits of each value, OVF=0 throughout.
REQ-031 VALUE=127 -> with DISPLAY_SATURATE_EN: J=9, K=9, OVF=1; without it: J=2, K=7, OVF=1.
REQ-032 LOAD 35, then LOAD 80 at edge 4 -> the second LOAD is ignored and the result is J=3, K=5; LOAD 80 at edge 9 -> J=8, K=0.
REQ-033 RST_N=0 at edge 5 of a conversion of 63 -> J=K=0, BUSY=0, SEL=0 next cycle; the conversion is not completed.
REQ-034 PRESCALE=3 -> after reset SEL toggles at edges 3, 6, 9, ... (period 6); with PRESCALE=1, SEL toggles every edge, unaffected by LOAD.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
//
// Converts a 7-bit binary value (0..127) into two BCD digits with a
// shift-add-3 (double-dabble) engine. It also generates a free-running
// digit-select square wave for a two-digit multiplexed display.
//
// Conversion timing, counted from the LOAD edge (edge 0):
//   edge 0     : capture VALUE, clear scratch and bit counter, raise BUSY
//   edges 1..7 : one shift-add-3 iteration per edge
//   edge 8     : register J/K/OVF, drop BUSY, return to IDLE
// A new LOAD is accepted on edge 9, which gives back-to-back throughput of
// 9 cycles.
//
// Optional feature macro: DISPLAY_SATURATE_EN
//   defined     : values above 99 display as 9/9 with OVF=1
//   not defined : values above 99 display the digits of VALUE-100 with OVF=1
//
// Parameters:
//   PRESCALE  clock cycles between SEL toggles (1 .. 2^20-1)
//
// Ports:
//   i_clk    in   1  system clock, rising-edge active
//   i_rst_n  in   1  synchronous active-low reset
//   i_value  in   7  binary value to display (0..127)
//   i_load   in   1  start strobe, sampled only in IDLE
//   o_j      out  4  BCD tens digit
//   o_k      out  4  BCD units digit
//   o_sel    out  1  digit-select square wave, period 2*PRESCALE cycles
//   o_busy   out  1  conversion in progress
//   o_ovf    out  1  last converted value was above 99
// -----------------------------------------------------------------------------
module display_scan_ctrl #(
    parameter int unsigned PRESCALE = 50000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [6:0] i_value,
    input  logic       i_load,
    output logic [3:0] o_j,
    output logic [3:0] o_k,
    output logic       o_sel,
    output logic       o_busy,
    output logic       o_ovf
);

    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_SHIFT = 2'd1;
    localparam logic [1:0]  S_DONE  = 2'd2;

    localparam logic [19:0] REFRESH_LAST = 20'(PRESCALE - 1);

    logic [1:0]  r_state;
    logic [6:0]  r_shift;
    logic [7:0]  r_scratch;
    logic [2:0]  r_bit_cnt;
    logic        r_hund;
    logic [3:0]  r_j;
    logic [3:0]  r_k;
    logic        r_ovf;
    logic        r_busy;
    logic [19:0] r_refresh;
    logic        r_sel;

    logic [7:0]  w_adj;

    // Add-3 correction applied to each nibble before the shift.
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        w_adj = r_scratch;
        if (r_scratch[3:0] >= 4'd5) begin
            w_adj[3:0] = r_scratch[3:0] + 4'd3;
        end
        if (r_scratch[7:4] >= 4'd5) begin
            w_adj[7:4] = r_scratch[7:4] + 4'd3;
        end
    end

    // Conversion FSM and datapath.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_scratch <= '0;
            r_bit_cnt <= '0;
            r_hund    <= 1'b0;
            r_j       <= '0;
            r_k       <= '0;
            r_ovf     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_load) begin
                        r_shift   <= i_value;
                        r_scratch <= '0;
                        r_bit_cnt <= '0;
                        r_hund    <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // Bit 7 of the adjusted scratch is the hundreds carry;
                    // it leaves the register but is remembered for OVF.
                    r_scratch <= {w_adj[6:0], r_shift[6]};
                    r_shift   <= {r_shift[5:0], 1'b0};
                    r_hund    <= r_hund | w_adj[7];
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd6) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
`ifdef DISPLAY_SATURATE_EN
                    if (r_hund) begin
                        r_j <= 4'd9;
                        r_k <= 4'd9;
                    end else begin
                        r_j <= r_scratch[7:4];
                        r_k <= r_scratch[3:0];
                    end
`else
                    r_j <= r_scratch[7:4];
                    r_k <= r_scratch[3:0];
`endif
                    r_ovf   <= r_hund;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Free-running refresh divider. It is independent of the FSM.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_refresh <= '0;
            r_sel     <= 1'b0;
        end else if (r_refresh == REFRESH_LAST) begin
            r_refresh <= '0;
            r_sel     <= ~r_sel;
        end else begin
            r_refresh <= r_refresh + 20'd1;
        end
    end

    assign o_j    = r_j;
    assign o_k    = r_k;
    assign o_ovf  = r_ovf;
    assign o_busy = r_busy;
    assign o_sel  = r_sel;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_scan_ctrl
//
// Directed bench for display_scan_ctrl. A behavioural model tracks the
// expected digits, BUSY and SEL from the decimal value and cycle counts, and
// a compare process checks both instances on every falling edge. Literal
// expectations at key points pin the model itself.
// The main instance uses PRESCALE=3. A second instance uses PRESCALE=1 and
// shares the same stimulus.
// Honours DISPLAY_SATURATE_EN for the above-99 expectations.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] value;
    logic       load;

    logic [3:0] j3, k3, j1, k1;
    logic       sel3, busy3, ovf3, sel1, busy1, ovf1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    display_scan_ctrl #(.PRESCALE(3)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_value(value), .i_load(load),
        .o_j(j3), .o_k(k3), .o_sel(sel3), .o_busy(busy3), .o_ovf(ovf3)
    );

    display_scan_ctrl #(.PRESCALE(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_value(value), .i_load(load),
        .o_j(j1), .o_k(k1), .o_sel(sel1), .o_busy(busy1), .o_ovf(ovf1)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_left  = 0;   // edges remaining until the result appears
    int m_v     = 0;
    int m_j     = 0;
    int m_k     = 0;
    int m_ovf   = 0;
    int m_cyc   = 0;   // edges with reset released since the last reset
    bit m_valid = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_left  = 0;
            m_j     = 0;
            m_k     = 0;
            m_ovf   = 0;
            m_cyc   = 0;
            m_valid = 1;
        end else begin
            m_cyc++;
            if (m_left == 0) begin
                if (load) begin
                    m_v    = int'(value);
                    m_left = 8;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    if (m_v > 99) begin
                        m_ovf = 1;
`ifdef DISPLAY_SATURATE_EN
                        m_j = 9;
                        m_k = 9;
`else
                        m_j = (m_v - 100) / 10;
                        m_k = (m_v - 100) % 10;
`endif
                    end else begin
                        m_ovf = 0;
                        m_j   = m_v / 10;
                        m_k   = m_v % 10;
                    end
                end
            end
        end
    end

    // Compare both instances against the model on every falling edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("busy3", int'(busy3), int'(m_left > 0));
            check("j3",    int'(j3),    m_j);
            check("k3",    int'(k3),    m_k);
            check("ovf3",  int'(ovf3),  m_ovf);
            check("sel3",  int'(sel3),  (m_cyc / 3) % 2);
            check("sel1",  int'(sel1),  m_cyc % 2);
            check("j1",    int'(j1),    m_j);
            check("busy1", int'(busy1), int'(m_left > 0));
        end
    end

    // Caller stands at a falling edge; returns just after edge 8.
    task automatic conv(input int v);
        value = 7'(v);
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        load  = 1'b1;      // coincident with reset: must be discarded
        value = 7'd99;
        repeat (3) @(negedge clk);
        check("rst_j",    int'(j3),    0);
        check("rst_busy", int'(busy3), 0);
        check("rst_sel",  int'(sel3),  0);
        rst_n = 1'b1;
        load  = 1'b0;

        // A single conversion of 47.
        value = 7'd47;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        check("busy_after_e0", int'(busy3), 1);
        repeat (7) @(negedge clk);
        check("busy_after_e7", int'(busy3), 1);
        check("j_held_e7",     int'(j3),    0);
        @(negedge clk);
        check("v47_j",    int'(j3),    4);
        check("v47_k",    int'(k3),    7);
        check("v47_ovf",  int'(ovf3),  0);
        check("v47_busy", int'(busy3), 0);

        // Back-to-back sweep of 0..99.
        for (int v = 0; v < 100; v++) conv(v);
        check("v99_j", int'(j3), 9);
        check("v99_k", int'(k3), 9);

        conv(127);
`ifdef DISPLAY_SATURATE_EN
        check("v127_j", int'(j3), 9);
        check("v127_k", int'(k3), 9);
`else
        check("v127_j", int'(j3), 2);
        check("v127_k", int'(k3), 7);
`endif
        check("v127_ovf", int'(ovf3), 1);
        conv(100);
        check("v100_ovf", int'(ovf3), 1);
        conv(5);
        check("v5_ovf", int'(ovf3), 0);

        // A LOAD during SHIFT is ignored.
        value = 7'd35;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        repeat (3) @(negedge clk);
        value = 7'd80;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        repeat (4) @(negedge clk);
        check("v35_j", int'(j3), 3);
        check("v35_k", int'(k3), 5);
        conv(80);
        check("v80_j", int'(j3), 8);
        check("v80_k", int'(k3), 0);

        // Reset at edge 5 of a conversion of 63.
        value = 7'd63;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        load  = 1'b1;
        @(negedge clk);
        check("midrst_j",    int'(j3),    0);
        check("midrst_k",    int'(k3),    0);
        check("midrst_busy", int'(busy3), 0);
        check("midrst_sel",  int'(sel3),  0);
        rst_n = 1'b1;
        load  = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_j", int'(j3), 0);
        conv(63);
        check("v63_j", int'(j3), 6);
        check("v63_k", int'(k3), 3);

        // Let SEL run freely for a few periods.
        repeat (12) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
